// File: rtl/stat_vector_harness.sv
// LFSR stimulus / MISR response harness for 32-in/32-out combinational Stat netlists.
// Each run applies num_vectors vectors, compacts the responses and compares against a golden signature.
module stat_vector_harness #(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] TAPS   = 'h00400007,
  parameter logic [WIDTH-1:0] SEED   = 'h00000001,
  parameter int               SETTLE = 1,
  parameter int               CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_vectors,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] expected,
  output logic [WIDTH-1:0] stim_out,
  input  logic [WIDTH-1:0] resp_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature
);

  localparam int               SET_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, APPLY, FINISH} state_t;

  // Galois shift shared by the stimulus generator and the response compactor.
  function automatic logic [WIDTH-1:0] sh(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? TAPS : '0);
  endfunction

  state_t           state;
  logic [WIDTH-1:0] lfsr;
  logic [WIDTH-1:0] misr;
  logic [WIDTH-1:0] exp_lat;
  logic [CNT_W-1:0] vec_cnt;
  logic [CNT_W-1:0] num_lat;
  logic [SET_W-1:0] set_cnt;

  logic [WIDTH-1:0] misr_next;
  logic             capture;
  logic             last_vec;

  assign misr_next = sh(misr) ^ resp_in;
  assign capture   = (set_cnt == SET_LAST);
  assign last_vec  = (vec_cnt == num_lat - CNT_W'(1));

  assign stim_out  = lfsr;
  assign signature = misr;
  assign busy      = (state == APPLY);

  // NOTE: every state register uses <= so all updates in a cycle see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      lfsr    <= '0;
      misr    <= '0;
      exp_lat <= '0;
      vec_cnt <= '0;
      num_lat <= '0;
      set_cnt <= '0;
      done    <= 1'b0;
      pass    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            misr    <= '0;
            exp_lat <= expected;
            if (num_vectors != '0) begin
              lfsr    <= (seed == '0) ? SEED : seed;
              vec_cnt <= '0;
              set_cnt <= '0;
              num_lat <= num_vectors;
              pass    <= 1'b0;
              state   <= APPLY;
            end else begin
              // Empty run: the signature is all-zero, so compare that directly.
              pass  <= (expected == '0);
              done  <= 1'b1;
              state <= FINISH;
            end
          end
        end
        APPLY: begin
          if (abort) begin
            pass  <= 1'b0;
            state <= IDLE;
          end else if (capture) begin
            misr    <= misr_next;
            lfsr    <= sh(lfsr);
            vec_cnt <= vec_cnt + CNT_W'(1);
            set_cnt <= '0;
            if (last_vec) begin
              // pass is resolved alongside done so it is valid in the done cycle.
              pass  <= (misr_next == exp_lat);
              done  <= 1'b1;
              state <= FINISH;
            end
          end else begin
            set_cnt <= set_cnt + SET_W'(1);
          end
        end
        FINISH: begin
          if (abort) pass <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stat_vector_harness.sv
// Self-checking bench for stat_vector_harness: directed table, hand sequences and a
// randomized comparison against a run-level signature model.
module tb_stat_vector_harness;

  localparam logic [31:0] TAPS = 32'h00400007;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  // SETTLE=1 instance
  logic        start = 1'b0, abort = 1'b0;
  logic [15:0] num_vectors = '0;
  logic [31:0] seed = '0, expected = '0, stim, resp, sig;
  logic        busy, done, pass;

  // SETTLE=3 instance, looped back
  logic        start3 = 1'b0, abort3 = 1'b0;
  logic [15:0] num3 = '0;
  logic [31:0] seed3 = '0, exp3 = '0, stim3, resp3, sig3;
  logic        busy3, done3, pass3;
  assign resp3 = stim3;

  stat_vector_harness dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .num_vectors(num_vectors), .seed(seed), .expected(expected),
    .stim_out(stim), .resp_in(resp), .busy(busy), .done(done),
    .pass(pass), .signature(sig)
  );

  stat_vector_harness #(.SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
    .num_vectors(num3), .seed(seed3), .expected(exp3),
    .stim_out(stim3), .resp_in(resp3), .busy(busy3), .done(done3),
    .pass(pass3), .signature(sig3)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Stand-in benchmark: 0 = tied low, 1 = loopback, 2 = keyed scramble.
  logic [1:0]  resp_mode = 2'd0;
  logic [31:0] key = '0;

  function automatic logic [31:0] bench_f(input logic [1:0] m, input logic [31:0] x,
                                          input logic [31:0] k);
    case (m)
      2'd1:    return x;
      2'd2:    return x ^ {x[15:0], x[31:16]} ^ k;
      default: return 32'h0;
    endcase
  endfunction

  always_comb resp = bench_f(resp_mode, stim, key);

  // Multiply by x modulo the feedback polynomial.
  function automatic logic [31:0] mulx(input logic [31:0] s);
    return (s << 1) ^ (s[31] ? TAPS : 32'h0);
  endfunction

  // Whole-run model: vector list from the seed, signature folded over the responses.
  function automatic void model_run(input logic [31:0] sd, input int n, input logic [1:0] m,
                                    input logic [31:0] k, output logic [31:0] first,
                                    output logic [31:0] last, output logic [31:0] s);
    logic [31:0] l;
    l = (sd == 32'h0) ? 32'h1 : sd;
    s = 32'h0; first = 32'h0; last = 32'h0;
    for (int i = 0; i < n; i++) begin
      if (i == 0) first = l;
      last = l;
      s = mulx(s) ^ bench_f(m, l, k);
      l = mulx(l);
    end
  endfunction

  // One run on the SETTLE=1 instance; lat counts edges from start to the done cycle.
  task automatic run1(input logic [31:0] sd, input logic [15:0] n, input logic [31:0] ex,
                      output logic [31:0] first, output logic [31:0] last,
                      output logic [31:0] s, output logic p, output int lat,
                      output int nbusy, output logic done_after, output logic pass_after);
    int e;
    @(negedge clk);
    seed = sd; num_vectors = n; expected = ex; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    e = 0; nbusy = 0; first = 32'h0; last = 32'h0;
    while (!done && e < 200) begin
      if (busy) begin
        if (nbusy == 0) first = stim;
        last = stim;
        nbusy++;
      end
      @(negedge clk);
      e++;
    end
    lat = e; s = sig; p = pass;
    @(negedge clk);
    done_after = done; pass_after = pass;
  endtask

  typedef struct {
    string       name;
    logic [31:0] sd;
    logic [15:0] n;
    logic [1:0]  mode;
    logic [31:0] ex;
    logic [31:0] first;
    logic [31:0] last;
    logic [31:0] sig;
    logic        pass;
    logic        chk_pass;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [31:0] first, last, s, mf, ml, ms, ex;
    logic        p, da, pa, saw_done;
    int          lat, nb, n, e;

    tbl[0] = '{"zero_resp",  32'h1,  16'd4,  2'd0, 32'h0, 32'h1, 32'h8,        32'h0, 1'b1, 1'b1};
    tbl[1] = '{"loop_n1",    32'h1,  16'd1,  2'd1, 32'h0, 32'h1, 32'h1,        32'h1, 1'b0, 1'b1};
    tbl[2] = '{"loop_n2",    32'h1,  16'd2,  2'd1, 32'h0, 32'h1, 32'h2,        32'h0, 1'b1, 1'b1};
    tbl[3] = '{"loop_n2_e1", 32'h1,  16'd2,  2'd1, 32'h1, 32'h1, 32'h2,        32'h0, 1'b0, 1'b1};
    tbl[4] = '{"lfsr_wrap",  32'h1,  16'd33, 2'd0, 32'h0, 32'h1, 32'h00400007, 32'h0, 1'b1, 1'b1};
    tbl[5] = '{"zero_seed",  32'h0,  16'd1,  2'd0, 32'h0, 32'h1, 32'h1,        32'h0, 1'b1, 1'b1};
    tbl[6] = '{"zero_count", 32'h5,  16'd0,  2'd0, 32'h0, 32'h0, 32'h0,        32'h0, 1'b0, 1'b0};

    #12;
    check("rst_stim", stim, 32'h0);
    check("rst_sig", sig, 32'h0);
    check("rst_flags", {29'h0, busy, done, pass}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      resp_mode = tbl[i].mode;
      run1(tbl[i].sd, tbl[i].n, tbl[i].ex, first, last, s, p, lat, nb, da, pa);
      check({tbl[i].name, "_lat"}, lat, 32'(tbl[i].n));
      check({tbl[i].name, "_nbusy"}, nb, 32'(tbl[i].n));
      check({tbl[i].name, "_first"}, first, tbl[i].first);
      check({tbl[i].name, "_last"}, last, tbl[i].last);
      check({tbl[i].name, "_sig"}, s, tbl[i].sig);
      check({tbl[i].name, "_done_pulse"}, da, 32'h0);
      if (tbl[i].chk_pass) begin
        check({tbl[i].name, "_pass"}, p, tbl[i].pass);
        check({tbl[i].name, "_pass_hold"}, pa, tbl[i].pass);
      end
    end

    // Randomized runs through a scrambling benchmark.
    for (int r = 0; r < 16; r++) begin
      resp_mode = 2'd2;
      key = $urandom;
      n = $urandom_range(1, 40);
      seed3 = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      model_run(seed3, n, 2'd2, key, mf, ml, ms);
      ex = ($urandom_range(0, 1) == 1) ? ms : (ms ^ (32'h1 << $urandom_range(0, 31)));
      run1(seed3, 16'(n), ex, first, last, s, p, lat, nb, da, pa);
      check("rnd_lat", lat, 32'(n));
      check("rnd_first", first, mf);
      check("rnd_last", last, ml);
      check("rnd_sig", s, ms);
      check("rnd_pass", p, (ms == ex) ? 32'h1 : 32'h0);
    end
    seed3 = 32'h0;

    // SETTLE=3 loopback: captures only at edges 3 and 6.
    begin
      logic [31:0] exp_sig[7];
      logic [31:0] exp_stim[7];
      exp_sig  = '{32'h0, 32'h0, 32'h0, 32'h1, 32'h1, 32'h1, 32'h0};
      exp_stim = '{32'h1, 32'h1, 32'h1, 32'h2, 32'h2, 32'h2, 32'h4};
      @(negedge clk);
      seed3 = 32'h1; num3 = 16'd2; exp3 = 32'h0; start3 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start3 = 1'b0;
      for (int k = 0; k < 7; k++) begin
        check($sformatf("s3_sig_e%0d", k), sig3, exp_sig[k]);
        check($sformatf("s3_stim_e%0d", k), stim3, exp_stim[k]);
        check($sformatf("s3_done_e%0d", k), done3, (k == 6) ? 32'h1 : 32'h0);
        check($sformatf("s3_busy_e%0d", k), busy3, (k < 6) ? 32'h1 : 32'h0);
        if (k < 6) @(negedge clk);
      end
      check("s3_pass", pass3, 32'h1);
    end

    // start while busy is ignored.
    resp_mode = 2'd0;
    @(negedge clk);
    seed = 32'h1; num_vectors = 16'd5; expected = 32'h0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    e = 0; last = 32'h0;
    while (!done && e < 100) begin
      if (busy) last = stim;
      if (e == 2) begin
        seed = 32'h1234; num_vectors = 16'd3; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      e++;
    end
    start = 1'b0;
    check("busy_start_lat", e, 32'd5);
    check("busy_start_last", last, 32'h10);

    // abort at edge 2 of a 10-vector loopback run.
    resp_mode = 2'd1;
    @(negedge clk);
    seed = 32'h1; num_vectors = 16'd10; expected = 32'h0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("abort_pre_sig", sig, 32'h1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 32'h0);
    check("abort_sig_hold", sig, 32'h1);
    check("abort_stim_hold", stim, 32'h2);
    check("abort_pass", pass, 32'h0);
    saw_done = done;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      saw_done = saw_done | done;
    end
    check("abort_no_done", saw_done, 32'h0);

    // start and abort together in IDLE: start wins.
    start = 1'b1; abort = 1'b1; num_vectors = 16'd2;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start_beats_abort", busy, 32'h1);
    repeat (4) @(negedge clk);

    // Asynchronous reset mid-run.
    start = 1'b1; num_vectors = 16'd10; seed = 32'h1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_stim", stim, 32'h8);
    #2 rst_n = 1'b0;
    #1;
    check("arst_stim", stim, 32'h0);
    check("arst_sig", sig, 32'h0);
    check("arst_flags", {29'h0, busy, done, pass}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", {30'h0, busy, done}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stat_vector_harness.md
# stat_vector_harness

Self-checking stimulus/response harness for the generated 32-in/32-out combinational Stat benchmark circuits. An LFSR produces pseudo-random input vectors that drive the benchmark's primary inputs. A MISR compacts the benchmark's primary outputs into a signature, which is compared against an expected value at the end of a run. The block sits on the far side of the benchmark boundary: it sources the inputs and sinks the outputs, so one harness can exercise any 32/32 Stat netlist, whether original or locked.

## Interface
- WIDTH, 32, vector width of both stimulus and response.
- TAPS, 32'h00400007, Galois feedback mask (x^32+x^22+x^2+x+1); shared by LFSR and MISR.
- SEED, 32'h00000001, substitute seed used when the `seed` input is zero.
- SETTLE, 1, cycles each vector is held before its response is captured (≥1).
- CNT_W, 16, width of the vector counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- start  in  1  begin a run; sampled only in IDLE.
- abort  in  1  return to IDLE at the next edge without asserting done.
- num_vectors  in  CNT_W  vectors per run; latched at start.
- seed  in  WIDTH  LFSR seed; latched at start.
- expected  in  WIDTH  golden signature; latched at start.
- stim_out  out  WIDTH  drives benchmark inputs n1..n32 (bit 0 = n1).
- resp_in  in  WIDTH  benchmark outputs in port order, bit 0 = first output.
- busy  out  1  high in APPLY.
- done  out  1  one-cycle pulse at end of run.
- pass  out  1  signature==expected; valid from done, held until next start.
- signature  out  WIDTH  current MISR contents.

## Operation
- Shift operator: sh(s) = {s[30:0],1'b0} ^ (s[31] ? TAPS : 0).
- LFSR step: l <= sh(l).
- MISR step: m <= sh(m) ^ resp_in.
- States are IDLE, APPLY and FINISH.
- IDLE:
  - start=1 with num_vectors≠0: LFSR <= (seed==0 ? SEED : seed), MISR <= 0, vec_cnt <= 0, set_cnt <= 0, latch num_vectors and expected, pass <= 0 → APPLY.
  - start=1 with num_vectors==0: MISR <= 0 → FINISH.
- APPLY:
  - stim_out = LFSR.
  - While set_cnt < SETTLE-1: set_cnt++.
  - When set_cnt == SETTLE-1 (capture edge): MISR step, LFSR step, vec_cnt++, set_cnt <= 0.
  - Capture edge with vec_cnt == num_vectors-1 → FINISH.
- FINISH (one cycle): done=1, pass = (MISR == expected_latched) → IDLE.
- abort: takes priority in APPLY and FINISH → IDLE. No done pulse; pass is cleared to 0; signature holds its partial value.
- start is ignored while not in IDLE. start and abort together in IDLE: start wins.
- No arithmetic beyond vec_cnt, which is an unsigned CNT_W-bit counter; the maximum run is 2^CNT_W − 1 vectors.
- stim_out holds its last value in IDLE and FINISH.

## Timing
- Reset values: stim_out=0, busy=0, done=0, pass=0, signature=0, state IDLE. Reset mid-run applies these immediately (asynchronous) with no done pulse.
- start is sampled at edge 0. stim_out = first vector after edge 0. busy is high from edge 0 through the last capture edge.
- resp_in is sampled at capture edges S, 2S, …, N·S, where S=SETTLE and N=num_vectors. The benchmark is combinational, so resp_in must settle within S cycles of stim_out changing.
- done is high in the cycle after edge N·S and low after edge N·S+1. Start-to-done latency is N·S cycles.
- N=0: done is high in the cycle after edge 0.
- A new start is accepted on the first IDLE cycle after done.

## Test plan
- Zero response: seed=1, N=4, SETTLE=1, resp_in=0, expected=0 → stim_out sequence 1,2,4,8; done after edge 4; signature=0; pass=1.
- Loopback (resp_in=stim_out), seed=1:
  - N=1 → signature=0x00000001.
  - N=2 → signature=0x00000000; pass=1 with expected=0.
  - Same run with expected=1 → pass=0.
- LFSR wrap: seed=1, N=33, resp_in=0 → 33rd stim_out=0x00400007; done after edge 33.
- Zero seed and zero count:
  - seed=0 → first stim_out=SEED (0x00000001).
  - N=0 → done in the cycle after start, busy stays 0, signature=0.
- SETTLE=3, loopback, seed=1, N=2 → captures only at edges 3 and 6; done after edge 6; signature=0.
- Disruption:
  - abort at edge 2 of a 10-vector run → IDLE, no done, signature holds.
  - rst_n low mid-run → all outputs 0 asynchronously.
  - start asserted while busy → ignored.
